mealy_frame_sequencer: RTL

MEALY_FRAME_SEQUENCER -- requirements
Module: mealy_frame_sequencer

---
 rtl/mealy_frame_sequencer_pkg.sv | 42 ++++
 rtl/mealy_frame_sequencer_if.sv | 31 +++
 rtl/mealy_frame_sequencer_detector.sv | 48 ++++
 rtl/mealy_frame_sequencer.sv | 111 +++++++++++
 4 files changed

// File: rtl/mealy_frame_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mealy_frame_sequencer_pkg
// Shared constants for the frame sequencer, its detector and the bench:
//   - controller state encoding (IDLE / SHIFT / DONE)
//   - detector state encoding   (A / B / C as {y2,y1})
//   - default frame and counter widths
//   - det_next(): next-state function of the "101" recogniser
// No ports (package).
// -----------------------------------------------------------------------------
package mealy_frame_sequencer_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } ctrl_state_t;

    // {y2,y1}: A = nothing useful seen, B = seen "1", C = seen "10".
    typedef enum logic [1:0] {
        DET_A = 2'b00,
        DET_B = 2'b01,
        DET_C = 2'b10
    } det_state_t;

    // Overlapping "101" recogniser. Any '1' lands in B because a '1' is
    // always a valid start of the next match; code 11 falls back to A.
    function automatic logic [1:0] det_next(input logic [1:0] state,
                                            input logic       w_bit);
        logic [1:0] nxt;
        case (state)
            DET_A:   nxt = w_bit ? DET_B : DET_A;
            DET_B:   nxt = w_bit ? DET_B : DET_C;
            DET_C:   nxt = w_bit ? DET_B : DET_A;
            default: nxt = DET_A;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mealy_frame_sequencer_if.sv
// -----------------------------------------------------------------------------
// mealy_frame_sequencer_if
// Bundles the frame request and result signals of mealy_frame_sequencer so an
// environment can carry them as one object.
//   master : frame requester (drives start/data_in, observes results)
//   slave  : sequencer side  (consumes start/data_in, drives results)
// Signals: start, data_in[WIDTH], w, z, busy, done, z_count[CNT_W].
// Clock and reset are not part of the bundle.
// -----------------------------------------------------------------------------
interface mealy_frame_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             w;
    logic             z;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] z_count;

    modport master (
        output start, data_in,
        input  w, z, busy, done, z_count
    );

    modport slave (
        input  start, data_in,
        output w, z, busy, done, z_count
    );
endinterface

// File: rtl/mealy_frame_sequencer_detector.sv
// -----------------------------------------------------------------------------
// mealy_101_detector
// Mealy recogniser for the serial pattern "101" with overlap.
// Ports:
//   clk    in  system clock, rising edge
//   resetn in  asynchronous active-low reset (state -> A)
//   clr    in  synchronous force to state A (wins over en)
//   en     in  advance the state on this edge using w
//   w      in  serial input bit
//   z      out combinational hit: w=1 while in state C and enabled
// -----------------------------------------------------------------------------
module mealy_101_detector
    import mealy_frame_sequencer_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    input  logic w,
    output logic z
);

    // Kept as a raw 2-bit code so the unused 11 code is representable and
    // recovers through det_next().
    logic [1:0] r_state;
    logic [1:0] w_state_next;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= DET_A;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clr) begin
            w_state_next = DET_A;
        end else if (en) begin
            w_state_next = det_next(r_state, w);
        end
    end

    // Gated by en so a stale C left over from the last frame never shows.
    assign z = en & w & (r_state == DET_C);

endmodule

// File: rtl/mealy_frame_sequencer.sv
// -----------------------------------------------------------------------------
// mealy_frame_sequencer
// Shifts a WIDTH-bit frame out MSB-first into a "101" Mealy detector and
// counts the hits. A frame is requested with start in IDLE; the controller
// then spends WIDTH cycles in SHIFT and one cycle in DONE before returning to
// IDLE, giving a minimum frame period of WIDTH+2 cycles.
// Ports:
//   clk      in   system clock, rising edge
//   resetn   in   asynchronous active-low reset
//   start    in   frame request, only looked at in IDLE
//   data_in  in   frame word, captured on the accepting edge
//   w        out  serial bit currently presented to the detector (0 outside SHIFT)
//   z        out  Mealy detector output, same cycle as w
//   busy     out  high in SHIFT
//   done     out  one-cycle pulse in DONE
//   z_count  out  hits in the current/last frame, held until the next start
// Parameters: WIDTH 3..16 frame length; CNT_W must hold WIDTH/2.
// -----------------------------------------------------------------------------
module mealy_frame_sequencer
    import mealy_frame_sequencer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             w,
    output logic             z,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] z_count
);

    localparam int IDX_W = $clog2(WIDTH);

    ctrl_state_t      r_state;
    ctrl_state_t      w_state_next;
    logic [WIDTH-1:0] r_shift;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_zcnt;

    logic w_accept;
    logic w_shift_en;
    logic w_last_bit;
    logic w_serial;
    logic w_det_z;

    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_shift_en = (r_state == ST_SHIFT);
    assign w_last_bit = (r_idx == IDX_W'(WIDTH - 1));
    assign w_serial   = w_shift_en & r_shift[WIDTH-1];

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_last_bit) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    // The frame word is copied into r_shift on the accepting edge, so later
    // data_in activity cannot disturb a frame in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_shift <= '0;
            r_idx   <= '0;
            r_zcnt  <= '0;
        end else if (w_accept) begin
            r_shift <= data_in;
            r_idx   <= '0;
            r_zcnt  <= '0;
        end else if (w_shift_en) begin
            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
            r_idx   <= w_last_bit ? '0 : r_idx + IDX_W'(1);
            if (w_det_z) begin
                r_zcnt <= r_zcnt + CNT_W'(1);
            end
        end
    end

    // Cleared on the accepting edge so every frame starts from state A.
    mealy_101_detector u_det (
        .clk    (clk),
        .resetn (resetn),
        .clr    (w_accept),
        .en     (w_shift_en),
        .w      (w_serial),
        .z      (w_det_z)
    );

    assign w       = w_serial;
    assign z       = w_det_z;
    assign busy    = w_shift_en;
    assign done    = (r_state == ST_DONE);
    assign z_count = r_zcnt;

endmodule
